// File: rtl/adc_sampler_pkg.sv
// Shared definitions for the ADC sampler: register map, CTRL/STATUS bit
// positions, conversion FSM states and the byte-lane merge helper.
package adc_sampler_pkg;

   localparam logic [1:0] ADR_CTRL   = 2'd0;
   localparam logic [1:0] ADR_PERIOD = 2'd1;
   localparam logic [1:0] ADR_STATUS = 2'd2;
   localparam logic [1:0] ADR_DATA   = 2'd3;

   localparam int unsigned CTRL_EN      = 32'd0;
   localparam int unsigned CTRL_ONESHOT = 32'd1;
   localparam int unsigned CTRL_FLUSH   = 32'd2;
   localparam int unsigned CTRL_IRQ_EN  = 32'd3;

   localparam int unsigned STAT_EMPTY = 32'd5;
   localparam int unsigned STAT_FULL  = 32'd6;
   localparam int unsigned STAT_OVF   = 32'd7;
   localparam int unsigned STAT_MISS  = 32'd8;

   localparam int unsigned SAMPLE_W = 32'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   // Replace only the byte lanes selected by sel; other lanes keep old_val.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous sample FIFO with push/pop/flush; a full FIFO still accepts a
// push when a pop happens in the same cycle. Flush overrides everything.
module adc_sample_fifo
   import adc_sampler_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty,
   output logic [4:0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;
   logic          full_s;
   logic          empty_s;

   assign full_s  = (count_r == CW'(DEPTH));
   assign empty_s = (count_r == CW'(0));

   // Qualify requests against occupancy; flush suppresses both.
   always_comb begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
      if (flush) begin
         do_push_s = 1'b0;
         do_pop_s  = 1'b0;
      end else begin
         do_pop_s  = pop & ~empty_s;
         do_push_s = push & (~full_s | do_pop_s);
      end
   end

   // Pointer and occupancy update.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= CW'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   // Sample storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign full  = full_s;
   assign empty = empty_s;
   assign count = 5'(count_r);

endmodule

// File: rtl/adc_sampler.sv
// Wishbone-controlled periodic SAR ADC sampler: period timer and one-shot
// triggers drive a START/WAIT conversion FSM whose results fill a FIFO.
module adc_sampler
   import adc_sampler_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int PERIOD_W   = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        adc_start,
   input  logic        adc_done,
   input  logic [7:0]  adc_data,
   output logic        irq
);

   logic                ack_r;
   logic [31:0]         dat_r;
   logic                req_s;
   logic                wr_s;
   logic                rd_s;
   logic [1:0]          reg_sel_s;
   logic                ctrl_wr_s;
   logic                stat_wr_s;
   logic                period_wr_s;
   logic [31:0]         period_merge_s;
   logic                ctrl_en_r;
   logic                ctrl_irq_en_r;
   logic [PERIOD_W-1:0] period_r;
   logic [PERIOD_W-1:0] timer_r;
   logic                tick_s;
   logic                oneshot_s;
   logic                flush_s;
   logic                trigger_s;
   logic                ovf_r;
   logic                miss_r;
   logic                ovf_set_s;
   logic                miss_set_s;
   state_e              state_r;
   state_e              state_next_s;
   logic                adc_start_r;
   logic                done_prev_r;
   logic                done_rise_s;
   logic                push_s;
   logic                pop_s;
   logic [7:0]          fifo_head_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [4:0]          fifo_count_s;
   logic [31:0]         rd_data_s;
   logic                irq_r;
   logic                unused_s;

   // ack_r blocks a second access while the master still holds stb.
   assign req_s       = wbs_stb_i & wbs_cyc_i & ~ack_r;
   assign wr_s        = req_s & wbs_we_i;
   assign rd_s        = req_s & ~wbs_we_i;
   assign reg_sel_s   = wbs_adr_i[3:2];
   assign ctrl_wr_s   = wr_s & (reg_sel_s == ADR_CTRL) & wbs_sel_i[0];
   assign stat_wr_s   = wr_s & (reg_sel_s == ADR_STATUS);
   assign period_wr_s = wr_s & (reg_sel_s == ADR_PERIOD);
   assign oneshot_s   = ctrl_wr_s & wbs_dat_i[CTRL_ONESHOT];
   assign flush_s     = ctrl_wr_s & wbs_dat_i[CTRL_FLUSH];
   assign pop_s       = rd_s & (reg_sel_s == ADR_DATA) & ~fifo_empty_s;

   assign period_merge_s = byte_merge(32'(period_r), wbs_dat_i, wbs_sel_i);
   assign unused_s = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i, period_merge_s};

   assign tick_s      = ctrl_en_r & (timer_r == PERIOD_W'(0));
   assign trigger_s   = tick_s | oneshot_s;
   assign done_rise_s = adc_done & ~done_prev_r;
   assign ovf_set_s   = push_s & fifo_full_s & ~pop_s & ~flush_s;

   // Register read mux; DATA reports valid only when a sample is present.
   always_comb begin
      rd_data_s = 32'h0000_0000;
      case (reg_sel_s)
         ADR_CTRL:   rd_data_s = {28'h000_0000, ctrl_irq_en_r, 2'b00, ctrl_en_r};
         ADR_PERIOD: rd_data_s = 32'(period_r);
         ADR_STATUS: rd_data_s = {23'h00_0000, miss_r, ovf_r, fifo_full_s,
                                  fifo_empty_s, fifo_count_s};
         ADR_DATA:   rd_data_s = fifo_empty_s ? 32'h0000_0000
                                              : {1'b1, 23'h00_0000, fifo_head_s};
         default:    rd_data_s = 32'h0000_0000;
      endcase
   end

   // Bus response, control/status registers and interrupt.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_r         <= 1'b0;
         dat_r         <= 32'h0000_0000;
         ctrl_en_r     <= 1'b0;
         ctrl_irq_en_r <= 1'b0;
         period_r      <= PERIOD_W'(0);
         ovf_r         <= 1'b0;
         miss_r        <= 1'b0;
         irq_r         <= 1'b0;
      end else begin
         ack_r <= req_s;
         dat_r <= rd_s ? rd_data_s : 32'h0000_0000;
         if (ctrl_wr_s) begin
            ctrl_en_r     <= wbs_dat_i[CTRL_EN];
            ctrl_irq_en_r <= wbs_dat_i[CTRL_IRQ_EN];
         end
         if (period_wr_s) begin
            period_r <= period_merge_s[PERIOD_W-1:0];
         end
         if (ovf_set_s) begin
            ovf_r <= 1'b1;
         end else if (stat_wr_s && wbs_sel_i[0] && wbs_dat_i[STAT_OVF]) begin
            ovf_r <= 1'b0;
         end
         if (miss_set_s) begin
            miss_r <= 1'b1;
         end else if (stat_wr_s && wbs_sel_i[1] && wbs_dat_i[STAT_MISS]) begin
            miss_r <= 1'b0;
         end
         irq_r <= ctrl_irq_en_r & ~fifo_empty_s;
      end
   end

   // Period down-counter; disabled timer tracks PERIOD so enable starts a full interval.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         timer_r <= PERIOD_W'(0);
      end else if (!ctrl_en_r || timer_r == PERIOD_W'(0)) begin
         timer_r <= period_r;
      end else begin
         timer_r <= timer_r - PERIOD_W'(1);
      end
   end

   // Conversion FSM next state, capture push and missed-trigger detection.
   always_comb begin
      state_next_s = state_r;
      push_s       = 1'b0;
      miss_set_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (trigger_s) begin
               state_next_s = ST_START;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_START: begin
            state_next_s = ST_WAIT;
            miss_set_s   = trigger_s;
         end
         ST_WAIT: begin
            miss_set_s = trigger_s;
            if (done_rise_s) begin
               state_next_s = ST_IDLE;
               push_s       = 1'b1;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, registered start strobe and adc_done history.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r     <= ST_IDLE;
         adc_start_r <= 1'b0;
         done_prev_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         adc_start_r <= (state_next_s == ST_START);
         done_prev_r <= adc_done;
      end
   end

   adc_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (SAMPLE_W)
   ) u_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .push      (push_s),
      .push_data (adc_data),
      .pop       (pop_s),
      .flush     (flush_s),
      .head      (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   assign wbs_ack_o = ack_r;
   assign wbs_dat_o = dat_r;
   assign adc_start = adc_start_r;
   assign irq       = irq_r;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler with an ADC response model and a sample
// scoreboard checked on every DATA read.
module tb_adc_sampler;

   localparam int DEPTH = 8;
   localparam int LAT   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i, wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        adc_start;
   logic        adc_done = 1'b0;
   logic [7:0]  adc_data = 8'h00;
   logic        irq;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          start_q[$];
   logic [7:0]  exp_q[$];
   logic        sb_track = 1'b0;
   logic [7:0]  seed_data = 8'h00;
   int          conv_n = 0;
   int          model_cnt = 0;

   adc_sampler #(.FIFO_DEPTH(DEPTH), .PERIOD_W(16)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (wbs_stb_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .adc_start (adc_start),
      .adc_done  (adc_done),
      .adc_data  (adc_data),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (adc_start) start_q.push_back(cyc);
   end

   // ADC model: one-cycle done pulse LAT cycles after the start cycle.
   always @(negedge clk) begin
      if (adc_done) adc_done = 1'b0;
      if (model_cnt != 0) begin
         model_cnt = model_cnt - 1;
         if (model_cnt == 0) begin
            adc_data = seed_data + 8'(conv_n);
            adc_done = 1'b1;
            if (sb_track && exp_q.size() < DEPTH) exp_q.push_back(adc_data);
            conv_n = conv_n + 1;
         end
      end
      if (adc_start) model_cnt = LAT;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wb_rw(input logic we, input logic [3:0] off, input logic [31:0] d,
                        input logic [3:0] sel, output logic [31:0] q);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = {28'h000_0000, off}; wbs_dat_i = d; wbs_sel_i = sel;
      @(posedge clk); #1;
      check("ack_pulse", {31'h0, wbs_ack_o}, 32'h1);
      q = wbs_dat_o;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      @(posedge clk); #1;
      check("ack_low_after", {31'h0, wbs_ack_o}, 32'h0);
   endtask

   task automatic wb_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] q;
      wb_rw(1'b1, off, d, sel, q);
   endtask

   task automatic check_read(input string tag, input logic [3:0] off, input logic [31:0] exp);
      logic [31:0] q;
      wb_rw(1'b0, off, 32'h0, 4'h0, q);
      check(tag, q, exp);
   endtask

   task automatic read_data_check(input string tag);
      logic [31:0] q;
      logic [31:0] e;
      if (exp_q.size() != 0) e = {1'b1, 23'h0, exp_q.pop_front()};
      else e = 32'h0;
      wb_rw(1'b0, 4'hC, 32'h0, 4'h0, q);
      check(tag, q, e);
   endtask

   task automatic wait_starts(input int target, input int budget);
      for (int k = 0; k < budget && start_q.size() < target; k++) @(posedge clk);
      #1;
      check("starts_seen", {31'h0, start_q.size() >= target}, 32'h1);
   endtask

   initial begin
      int n0;
      int ns;
      rst = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;
      cycles(3);
      check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
      check("rst_dat", wbs_dat_o, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_start", {31'h0, adc_start}, 32'h0);
      rst = 1'b0;
      cycles(1);
      check_read("rst_ctrl", 4'h0, 32'h0);
      check_read("rst_status", 4'h8, 32'h20);
      check_read("rst_period", 4'h4, 32'h0);

      // one-shot capture of 0xA5
      sb_track = 1'b1;
      seed_data = 8'hA5 - 8'(conv_n);
      wb_write(4'h0, 32'h2, 4'hF);
      cycles(10);
      check_read("oneshot_status", 4'h8, 32'h1);
      check_read("oneshot_ctrl_reads0", 4'h0, 32'h0);
      check(  "oneshot_sb_head", {24'h0, exp_q[0]}, 32'hA5);
      read_data_check("oneshot_data");
      read_data_check("oneshot_data_empty");

      // interrupt then flush
      wb_write(4'h0, 32'h8, 4'hF);
      check("irq_empty", {31'h0, irq}, 32'h0);
      wb_write(4'h0, 32'hA, 4'hF);
      cycles(10);
      check("irq_set", {31'h0, irq}, 32'h1);
      wb_write(4'h0, 32'hC, 4'hF);
      exp_q.delete();
      check("irq_after_flush", {31'h0, irq}, 32'h0);
      check_read("flush_status", 4'h8, 32'h20);

      // periodic sampling, PERIOD=9
      seed_data = 8'h30;
      wb_write(4'h4, 32'd9, 4'hF);
      n0 = start_q.size();
      wb_write(4'h0, 32'h1, 4'hF);
      wait_starts(n0 + 4, 200);
      wb_write(4'h0, 32'h0, 4'hF);
      cycles(12);
      for (int i = 0; i < 3 && n0 + i + 1 < start_q.size(); i++)
         check("p9_gap", 32'(start_q[n0+i+1] - start_q[n0+i]), 32'd10);
      ns = start_q.size() - n0;
      check_read("p9_status", 4'h8, 32'(ns));
      for (int i = 0; i < ns; i++) read_data_check("p9_data");
      check_read("p9_drained", 4'h8, 32'h20);

      // overflow with 9 conversions
      seed_data = 8'h10;
      for (int i = 0; i < 9; i++) begin
         wb_write(4'h0, 32'h2, 4'hF);
         cycles(10);
      end
      check_read("ovf_status", 4'h8, 32'hC8);
      wb_write(4'h8, 32'h80, 4'hF);
      check_read("ovf_cleared", 4'h8, 32'h48);
      read_data_check("ovf_first");
      check_read("ovf_after_pop", 4'h8, 32'h07);
      wb_write(4'h0, 32'h4, 4'hF);
      exp_q.delete();
      check_read("ovf_flushed", 4'h8, 32'h20);

      // back-to-back triggers, PERIOD=0
      seed_data = 8'h60;
      wb_write(4'h4, 32'h0, 4'hF);
      n0 = start_q.size();
      wb_write(4'h0, 32'h1, 4'hF);
      wait_starts(n0 + 3, 100);
      wb_write(4'h0, 32'h0, 4'hF);
      cycles(12);
      for (int i = 0; i < 2 && n0 + i + 1 < start_q.size(); i++)
         check("p0_gap", 32'(start_q[n0+i+1] - start_q[n0+i]), 32'd6);
      ns = start_q.size() - n0;
      check_read("p0_miss", 4'h8, 32'h100 | 32'(ns));
      wb_write(4'h8, 32'h100, 4'b0001);
      check_read("miss_wrong_lane", 4'h8, 32'h100 | 32'(ns));
      wb_write(4'h8, 32'h100, 4'b0010);
      check_read("miss_cleared", 4'h8, 32'(ns));
      for (int i = 0; i < ns; i++) read_data_check("p0_data");
      check_read("p0_drained", 4'h8, 32'h20);

      // byte lanes and ignored DATA write
      wb_write(4'h4, 32'h0000ABCD, 4'hF);
      wb_write(4'h4, 32'hFFFFFF12, 4'b0001);
      check_read("lane0", 4'h4, 32'hAB12);
      wb_write(4'h4, 32'h00003400, 4'b0010);
      check_read("lane1", 4'h4, 32'h3412);
      wb_write(4'hC, 32'hFFFFFFFF, 4'hF);
      check_read("data_write_ignored", 4'h8, 32'h20);

      // stb held two cycles yields a single ack
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = 32'h8; wbs_sel_i = 4'hF;
      @(posedge clk); #1;
      check("hold_ack1", {31'h0, wbs_ack_o}, 32'h1);
      check("hold_dat1", wbs_dat_o, 32'h20);
      @(posedge clk); #1;
      check("hold_ack2", {31'h0, wbs_ack_o}, 32'h0);
      check("hold_dat2", wbs_dat_o, 32'h0);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      cycles(1);

      // reset during WAIT, later done pulse must not be captured
      sb_track = 1'b0;
      wb_write(4'h0, 32'hA, 4'hF);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cycles(10);
      check("rstw_irq", {31'h0, irq}, 32'h0);
      check("rstw_start", {31'h0, adc_start}, 32'h0);
      check_read("rstw_status", 4'h8, 32'h20);
      check_read("rstw_ctrl", 4'h0, 32'h0);
      check_read("rstw_period", 4'h4, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_sampler.md
ADC_SAMPLER -- requirements
Module: adc_sampler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter PERIOD_W, default 16, width of the sample-period register.
REQ-003 SHALL have port wb_clk_i  in  1  the only clock, rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone slave strobe/cycle/write.
REQ-006 SHALL have ports wbs_sel_i in 4, wbs_dat_i in 32, wbs_adr_i in 32; only adr[3:2] decoded.
REQ-007 SHALL have ports wbs_ack_o out 1, wbs_dat_o out 32.
REQ-008 SHALL have port adc_start  out  1  conversion request to the SAR ADC.
REQ-009 SHALL have port adc_done  in  1  ADC conversion-done level, synchronous to wb_clk_i.
REQ-010 SHALL have port adc_data  in  8  ADC result, valid while adc_done high.
REQ-011 SHALL have port irq  out  1  level interrupt.

Function
REQ-012 Registers: 0x0 CTRL (b0 EN, b1 ONESHOT, b2 FLUSH, b3 IRQ_EN); 0x4 PERIOD[PERIOD_W-1:0]; 0x8 STATUS; 0xC DATA.
REQ-013 ONESHOT and FLUSH SHALL be self-clearing write-1 strobes; they read 0.
REQ-014 STATUS SHALL read {count[4:0] in [4:0], empty b5, full b6, OVF b7, MISS b8}; writing 1 to b7/b8 clears that sticky bit.
REQ-015 Wishbone: wbs_ack_o SHALL pulse exactly one cycle, one cycle after stb&cyc are first sampled high, and stay low the following cycle; wbs_dat_o valid during ack, 0 otherwise.
REQ-016 Writes SHALL honour wbs_sel_i per byte lane; writes to DATA are ignored.
REQ-017 DATA read SHALL return {valid b31, 23'b0, sample[7:0]} and pop the FIFO on the ack cycle; read while empty returns 0, no pointer change.
REQ-018 FSM states IDLE, START, WAIT; IDLE->START on trigger, START->WAIT after one cycle, WAIT->IDLE on adc_done rising edge.
REQ-019 adc_start SHALL be high only in START (exactly one cycle per conversion).
REQ-020 Rising edge of adc_done (registered previous value low, current high) in WAIT SHALL push adc_data into the FIFO; edges in IDLE/START are ignored.
REQ-021 Period timer: while EN, a down-counter loads PERIOD, decrements each cycle, issues a tick at 0 and reloads; PERIOD=0 means tick every cycle; EN=0 holds counter at PERIOD.
REQ-022 Trigger = tick or ONESHOT write; a trigger while FSM not IDLE SHALL be dropped and set MISS.
REQ-023 Push when full without simultaneous pop SHALL drop the sample and set OVF; push and pop in same cycle when full SHALL succeed with count unchanged.
REQ-024 FLUSH SHALL empty the FIFO next cycle; FLUSH with simultaneous push: FLUSH wins, FIFO empty.
REQ-025 irq SHALL equal IRQ_EN & !empty, registered (one cycle after count change).

Reset
REQ-026 On wb_rst_i high at a clock edge: FSM IDLE, adc_start 0, FIFO empty, CTRL 0, PERIOD 0, OVF/MISS 0, timer 0, wbs_ack_o 0, wbs_dat_o 0, irq 0.
REQ-027 Reset mid-conversion SHALL abandon it; a later adc_done edge while IDLE SHALL not push.

Structure
REQ-028 Package adc_sampler_pkg SHALL hold register offsets, CTRL/STATUS bit indices and the FSM state enum.
REQ-029 FIFO SHALL be sub-module adc_sample_fifo (synchronous, push/pop/flush, full/empty/count).

Verification
REQ-030 PERIOD=9, EN=1, ADC model done 4 cycles after start -> adc_start pulses every 10 cycles; FIFO gains one sample per pulse.
REQ-031 ONESHOT, adc_data=0xA5 -> DATA read returns 0x800000A5; second read returns 0x00000000.
REQ-032 9 conversions with no reads (depth 8) -> STATUS count=8, full=1, OVF=1; writing 0x80 to STATUS clears OVF.
REQ-033 PERIOD=0, ADC done latency 4 -> MISS=1, one start per 6 cycles (START+WAIT+IDLE).
REQ-034 wb_rst_i asserted in WAIT, then adc_done pulses -> FIFO stays empty, irq 0.
REQ-035 IRQ_EN=1, one sample captured -> irq 1; FLUSH -> empty=1, irq 0 next cycle.
